// File: rtl/issue_scoreboard_pkg.sv
// Shared constants and types for the dual-lane issue scoreboard.
package issue_scoreboard_pkg;

    localparam int DEFAULT_NREGS = 32;
    localparam int DEFAULT_CNT_W = 32;
    localparam int REG_AW        = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // x0 is hardwired zero, so it never participates in a dependency.
    function automatic logic is_real_reg(reg_addr_t addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-side issue request, writeback and status bundle for the scoreboard.
interface issue_scoreboard_if #(
    parameter int NREGS = issue_scoreboard_pkg::DEFAULT_NREGS,
    parameter int CNT_W = issue_scoreboard_pkg::DEFAULT_CNT_W
);
    import issue_scoreboard_pkg::*;

    logic             A_valid_i;
    reg_addr_t        A_rs1_addr_i;
    reg_addr_t        A_rs2_addr_i;
    logic             A_rs1_used_i;
    logic             A_rs2_used_i;
    reg_addr_t        A_rd_addr_i;
    logic             A_rd_write_i;

    logic             B_valid_i;
    reg_addr_t        B_rs1_addr_i;
    reg_addr_t        B_rs2_addr_i;
    logic             B_rs1_used_i;
    logic             B_rs2_used_i;
    reg_addr_t        B_rd_addr_i;
    logic             B_rd_write_i;

    logic             A_wb_valid_i;
    reg_addr_t        A_wb_addr_i;
    logic             B_wb_valid_i;
    reg_addr_t        B_wb_addr_i;
    logic             flush_i;

    logic             A_issue_o;
    logic             B_issue_o;
    logic             stall_o;
    logic [NREGS-1:0] busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output A_valid_i, A_rs1_addr_i, A_rs2_addr_i, A_rs1_used_i, A_rs2_used_i,
               A_rd_addr_i, A_rd_write_i,
        output B_valid_i, B_rs1_addr_i, B_rs2_addr_i, B_rs1_used_i, B_rs2_used_i,
               B_rd_addr_i, B_rd_write_i,
        output A_wb_valid_i, A_wb_addr_i, B_wb_valid_i, B_wb_addr_i, flush_i,
        input  A_issue_o, B_issue_o, stall_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  A_valid_i, A_rs1_addr_i, A_rs2_addr_i, A_rs1_used_i, A_rs2_used_i,
               A_rd_addr_i, A_rd_write_i,
        input  B_valid_i, B_rs1_addr_i, B_rs2_addr_i, B_rs1_used_i, B_rs2_used_i,
               B_rd_addr_i, B_rd_write_i,
        input  A_wb_valid_i, A_wb_addr_i, B_wb_valid_i, B_wb_addr_i, flush_i,
        output A_issue_o, B_issue_o, stall_o, busy_o, stall_cnt_o
    );

endinterface

// File: rtl/issue_scoreboard_lane_hazard_check.sv
// Per-lane RAW/WAW check of one instruction's operands against the busy vector.
module issue_scoreboard_lane_hazard_check
    import issue_scoreboard_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS
) (
    input  logic [NREGS-1:0] busy,
    input  reg_addr_t        rs1_addr,
    input  reg_addr_t        rs2_addr,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  reg_addr_t        rd_addr,
    input  logic             rd_write,
    output logic             hazard
);

    always_comb begin
        hazard = 1'b0;
        if (rs1_used && is_real_reg(rs1_addr) && busy[rs1_addr]) begin
            hazard = 1'b1;
        end
        if (rs2_used && is_real_reg(rs2_addr) && busy[rs2_addr]) begin
            hazard = 1'b1;
        end
        if (rd_write && is_real_reg(rd_addr) && busy[rd_addr]) begin
            hazard = 1'b1;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-lane register scoreboard: grants in-order pair issue and tracks busy destinations.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    issue_scoreboard_if.slave sb
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [CNT_W-1:0] stall_cnt_q;

    logic a_hazard;
    logic b_hazard;
    logic pair_hazard;
    logic a_issue;
    logic b_issue;
    logic stall;

    issue_scoreboard_lane_hazard_check #(.NREGS(NREGS)) u_a_check (
        .busy     (busy_q),
        .rs1_addr (sb.A_rs1_addr_i),
        .rs2_addr (sb.A_rs2_addr_i),
        .rs1_used (sb.A_rs1_used_i),
        .rs2_used (sb.A_rs2_used_i),
        .rd_addr  (sb.A_rd_addr_i),
        .rd_write (sb.A_rd_write_i),
        .hazard   (a_hazard)
    );

    issue_scoreboard_lane_hazard_check #(.NREGS(NREGS)) u_b_check (
        .busy     (busy_q),
        .rs1_addr (sb.B_rs1_addr_i),
        .rs2_addr (sb.B_rs2_addr_i),
        .rs1_used (sb.B_rs1_used_i),
        .rs2_used (sb.B_rs2_used_i),
        .rd_addr  (sb.B_rd_addr_i),
        .rd_write (sb.B_rd_write_i),
        .hazard   (b_hazard)
    );

    // Lane B is younger: it may not consume or overwrite lane A's result in the same cycle.
    always_comb begin
        pair_hazard = 1'b0;
        if (sb.A_rd_write_i && is_real_reg(sb.A_rd_addr_i)) begin
            if ((sb.B_rs1_used_i && sb.B_rs1_addr_i == sb.A_rd_addr_i) ||
                (sb.B_rs2_used_i && sb.B_rs2_addr_i == sb.A_rd_addr_i) ||
                (sb.B_rd_write_i && sb.B_rd_addr_i == sb.A_rd_addr_i)) begin
                pair_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        a_issue = sb.A_valid_i && !sb.flush_i && !reset_i && !a_hazard;
        b_issue = sb.B_valid_i && a_issue && !b_hazard && !pair_hazard;
        stall   = sb.A_valid_i && !a_issue && !reset_i;
    end

    // Clears are applied before sets so a new writer survives a same-cycle retire.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (sb.A_wb_valid_i) begin
            clr_mask[sb.A_wb_addr_i] = 1'b1;
        end
        if (sb.B_wb_valid_i) begin
            clr_mask[sb.B_wb_addr_i] = 1'b1;
        end
        if (a_issue && sb.A_rd_write_i) begin
            set_mask[sb.A_rd_addr_i] = 1'b1;
        end
        if (b_issue && sb.B_rd_write_i) begin
            set_mask[sb.B_rd_addr_i] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || sb.flush_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Flush keeps the stall count; only reset clears it.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign sb.A_issue_o   = a_issue;
    assign sb.B_issue_o   = b_issue;
    assign sb.stall_o     = stall;
    assign sb.busy_o      = busy_q;
    assign sb.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against an in-flight-writer list model.
module tb_issue_scoreboard;

    localparam int NREGS   = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock_i = 1'b0;
    logic reset_i;

    always #5 clock_i = ~clock_i;

    issue_scoreboard_if #(.NREGS(NREGS), .CNT_W(CNT_W)) sb_if ();

    issue_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .sb      (sb_if)
    );

    int passCount;
    int checkCount;
    int stallCycles;
    int outstanding[$];

    task automatic idle_inputs();
        sb_if.A_valid_i    = 1'b0;
        sb_if.A_rs1_addr_i = '0;
        sb_if.A_rs2_addr_i = '0;
        sb_if.A_rs1_used_i = 1'b0;
        sb_if.A_rs2_used_i = 1'b0;
        sb_if.A_rd_addr_i  = '0;
        sb_if.A_rd_write_i = 1'b0;
        sb_if.B_valid_i    = 1'b0;
        sb_if.B_rs1_addr_i = '0;
        sb_if.B_rs2_addr_i = '0;
        sb_if.B_rs1_used_i = 1'b0;
        sb_if.B_rs2_used_i = 1'b0;
        sb_if.B_rd_addr_i  = '0;
        sb_if.B_rd_write_i = 1'b0;
        sb_if.A_wb_valid_i = 1'b0;
        sb_if.A_wb_addr_i  = '0;
        sb_if.B_wb_valid_i = 1'b0;
        sb_if.B_wb_addr_i  = '0;
        sb_if.flush_i      = 1'b0;
    endtask

    // A register is busy while some issued writer to it has not yet retired.
    function automatic bit model_busy(int r);
        if (r == 0) return 1'b0;
        foreach (outstanding[i]) begin
            if (outstanding[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NREGS-1:0] model_busy_vec();
        logic [NREGS-1:0] v;
        v = '0;
        foreach (outstanding[i]) v[outstanding[i]] = 1'b1;
        return v;
    endfunction

    function automatic int model_cnt();
        return (stallCycles > CNT_MAX) ? CNT_MAX : stallCycles;
    endfunction

    function automatic void model_grants(output bit ea, output bit eb, output bit es);
        bit aBlocked;
        bit bBlocked;
        int aDest;
        aBlocked = (sb_if.A_rs1_used_i && model_busy(int'(sb_if.A_rs1_addr_i))) ||
                   (sb_if.A_rs2_used_i && model_busy(int'(sb_if.A_rs2_addr_i))) ||
                   (sb_if.A_rd_write_i && model_busy(int'(sb_if.A_rd_addr_i)));
        ea = sb_if.A_valid_i && !sb_if.flush_i && !reset_i && !aBlocked;
        aDest = (sb_if.A_rd_write_i && sb_if.A_rd_addr_i != 0) ? int'(sb_if.A_rd_addr_i) : -1;
        bBlocked = (sb_if.B_rs1_used_i && model_busy(int'(sb_if.B_rs1_addr_i))) ||
                   (sb_if.B_rs2_used_i && model_busy(int'(sb_if.B_rs2_addr_i))) ||
                   (sb_if.B_rd_write_i && model_busy(int'(sb_if.B_rd_addr_i))) ||
                   (aDest >= 0 && sb_if.B_rs1_used_i && int'(sb_if.B_rs1_addr_i) == aDest) ||
                   (aDest >= 0 && sb_if.B_rs2_used_i && int'(sb_if.B_rs2_addr_i) == aDest) ||
                   (aDest >= 0 && sb_if.B_rd_write_i && int'(sb_if.B_rd_addr_i) == aDest);
        eb = sb_if.B_valid_i && ea && !bBlocked;
        es = sb_if.A_valid_i && !ea && !reset_i;
    endfunction

    // Advances one clock and applies retire, issue, flush and reset to the model.
    task automatic tick();
        bit ea, eb, es;
        model_grants(ea, eb, es);
        @(posedge clock_i);
        if (reset_i) begin
            outstanding.delete();
            stallCycles = 0;
        end else begin
            if (es) stallCycles++;
            if (sb_if.flush_i) begin
                outstanding.delete();
            end else begin
                for (int i = outstanding.size() - 1; i >= 0; i--) begin
                    if ((sb_if.A_wb_valid_i && outstanding[i] == int'(sb_if.A_wb_addr_i)) ||
                        (sb_if.B_wb_valid_i && outstanding[i] == int'(sb_if.B_wb_addr_i)))
                        outstanding.delete(i);
                end
                if (ea && sb_if.A_rd_write_i && sb_if.A_rd_addr_i != 0)
                    outstanding.push_back(int'(sb_if.A_rd_addr_i));
                if (eb && sb_if.B_rd_write_i && sb_if.B_rd_addr_i != 0)
                    outstanding.push_back(int'(sb_if.B_rd_addr_i));
            end
        end
        @(negedge clock_i);
    endtask

    task automatic test_reset();
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd5; sb_if.A_rd_write_i = 1'b1;
        sb_if.B_valid_i = 1'b1; sb_if.B_rd_addr_i = 5'd6; sb_if.B_rd_write_i = 1'b1;
        #1;
        if (sb_if.A_issue_o !== 1'b0) $display("[TB] FAIL reset_a_issue: got %b want 0", sb_if.A_issue_o); else passCount++; checkCount++;
        if (sb_if.B_issue_o !== 1'b0) $display("[TB] FAIL reset_b_issue: got %b want 0", sb_if.B_issue_o); else passCount++; checkCount++;
        if (sb_if.stall_o !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", sb_if.stall_o); else passCount++; checkCount++;
        if (sb_if.busy_o !== '0) $display("[TB] FAIL reset_busy: got %h want 0", sb_if.busy_o); else passCount++; checkCount++;
        if (sb_if.stall_cnt_o !== '0) $display("[TB] FAIL reset_cnt: got %0d want 0", sb_if.stall_cnt_o); else passCount++; checkCount++;
        tick();
        reset_i = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_write();
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd5; sb_if.A_rd_write_i = 1'b1;
        #1;
        if (sb_if.A_issue_o !== 1'b1) $display("[TB] FAIL write_a_issue: got %b want 1", sb_if.A_issue_o); else passCount++; checkCount++;
        if (sb_if.stall_o !== 1'b0) $display("[TB] FAIL write_stall: got %b want 0", sb_if.stall_o); else passCount++; checkCount++;
        tick();
        idle_inputs();
        #1;
        if (sb_if.busy_o !== 32'h0000_0020) $display("[TB] FAIL write_busy: got %h want 00000020", sb_if.busy_o); else passCount++; checkCount++;
    endtask

    task automatic test_raw_stall();
        sb_if.A_valid_i = 1'b1; sb_if.A_rs1_addr_i = 5'd5; sb_if.A_rs1_used_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (sb_if.stall_o !== 1'b1) $display("[TB] FAIL raw_stall: got %b want 1", sb_if.stall_o); else passCount++; checkCount++;
            if (sb_if.A_issue_o !== 1'b0) $display("[TB] FAIL raw_a_blocked: got %b want 0", sb_if.A_issue_o); else passCount++; checkCount++;
            tick();
        end
        sb_if.A_wb_valid_i = 1'b1; sb_if.A_wb_addr_i = 5'd5;
        #1;
        if (sb_if.A_issue_o !== 1'b0) $display("[TB] FAIL raw_wb_cycle_issue: got %b want 0", sb_if.A_issue_o); else passCount++; checkCount++;
        tick();
        sb_if.A_wb_valid_i = 1'b0;
        #1;
        if (sb_if.A_issue_o !== 1'b1) $display("[TB] FAIL raw_after_wb_issue: got %b want 1", sb_if.A_issue_o); else passCount++; checkCount++;
        if (sb_if.busy_o !== '0) $display("[TB] FAIL raw_busy_cleared: got %h want 0", sb_if.busy_o); else passCount++; checkCount++;
        if (sb_if.stall_cnt_o !== 4'd4) $display("[TB] FAIL raw_cnt: got %0d want 4", sb_if.stall_cnt_o); else passCount++; checkCount++;
        tick();
        idle_inputs();
    endtask

    task automatic test_pair_hazard();
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd3; sb_if.A_rd_write_i = 1'b1;
        sb_if.B_valid_i = 1'b1; sb_if.B_rs1_addr_i = 5'd3; sb_if.B_rs1_used_i = 1'b1;
        #1;
        if (sb_if.A_issue_o !== 1'b1) $display("[TB] FAIL pair_raw_a: got %b want 1", sb_if.A_issue_o); else passCount++; checkCount++;
        if (sb_if.B_issue_o !== 1'b0) $display("[TB] FAIL pair_raw_b: got %b want 0", sb_if.B_issue_o); else passCount++; checkCount++;
        tick();
        idle_inputs();
        sb_if.A_valid_i = 1'b1; sb_if.A_rs1_addr_i = 5'd3; sb_if.A_rs1_used_i = 1'b1;
        sb_if.A_wb_valid_i = 1'b1; sb_if.A_wb_addr_i = 5'd3;
        #1;
        if (sb_if.A_issue_o !== 1'b0) $display("[TB] FAIL pair_replay_blocked: got %b want 0", sb_if.A_issue_o); else passCount++; checkCount++;
        if (sb_if.busy_o !== 32'h0000_0008) $display("[TB] FAIL pair_busy3: got %h want 00000008", sb_if.busy_o); else passCount++; checkCount++;
        tick();
        sb_if.A_wb_valid_i = 1'b0;
        #1;
        if (sb_if.A_issue_o !== 1'b1) $display("[TB] FAIL pair_replay_issue: got %b want 1", sb_if.A_issue_o); else passCount++; checkCount++;
        tick();
        idle_inputs();
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd9; sb_if.A_rd_write_i = 1'b1;
        sb_if.B_valid_i = 1'b1; sb_if.B_rd_addr_i = 5'd9; sb_if.B_rd_write_i = 1'b1;
        #1;
        if (sb_if.B_issue_o !== 1'b0) $display("[TB] FAIL pair_waw_b: got %b want 0", sb_if.B_issue_o); else passCount++; checkCount++;
        tick();
        idle_inputs();
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd10; sb_if.A_rd_write_i = 1'b1;
        sb_if.B_valid_i = 1'b1; sb_if.B_rd_addr_i = 5'd11; sb_if.B_rd_write_i = 1'b1;
        sb_if.B_rs1_addr_i = 5'd12; sb_if.B_rs1_used_i = 1'b1;
        sb_if.A_wb_valid_i = 1'b1; sb_if.A_wb_addr_i = 5'd9;
        #1;
        if (sb_if.A_issue_o !== 1'b1 || sb_if.B_issue_o !== 1'b1)
            $display("[TB] FAIL pair_dual_issue: got A=%b B=%b want A=1 B=1", sb_if.A_issue_o, sb_if.B_issue_o);
        else passCount++;
        checkCount++;
        tick();
        idle_inputs();
        #1;
        if (sb_if.busy_o !== 32'h0000_0C00) $display("[TB] FAIL pair_busy_10_11: got %h want 00000c00", sb_if.busy_o); else passCount++; checkCount++;
        sb_if.A_wb_valid_i = 1'b1; sb_if.A_wb_addr_i = 5'd10;
        sb_if.B_wb_valid_i = 1'b1; sb_if.B_wb_addr_i = 5'd11;
        tick();
        idle_inputs();
    endtask

    task automatic test_x0();
        sb_if.A_valid_i = 1'b1; sb_if.A_rs1_used_i = 1'b1; sb_if.A_rs2_used_i = 1'b1; sb_if.A_rd_write_i = 1'b1;
        sb_if.B_valid_i = 1'b1; sb_if.B_rs1_used_i = 1'b1; sb_if.B_rs2_used_i = 1'b1; sb_if.B_rd_write_i = 1'b1;
        #1;
        if (sb_if.A_issue_o !== 1'b1 || sb_if.B_issue_o !== 1'b1)
            $display("[TB] FAIL x0_dual_issue: got A=%b B=%b want A=1 B=1", sb_if.A_issue_o, sb_if.B_issue_o);
        else passCount++;
        checkCount++;
        tick();
        idle_inputs();
        #1;
        if (sb_if.busy_o !== '0) $display("[TB] FAIL x0_busy: got %h want 0", sb_if.busy_o); else passCount++; checkCount++;
    endtask

    task automatic test_set_wins_flush();
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd7; sb_if.A_rd_write_i = 1'b1;
        sb_if.A_wb_valid_i = 1'b1; sb_if.A_wb_addr_i = 5'd7;
        #1;
        if (sb_if.A_issue_o !== 1'b1) $display("[TB] FAIL setwin_a_issue: got %b want 1", sb_if.A_issue_o); else passCount++; checkCount++;
        tick();
        idle_inputs();
        #1;
        if (sb_if.busy_o !== 32'h0000_0080) $display("[TB] FAIL setwin_busy7: got %h want 00000080", sb_if.busy_o); else passCount++; checkCount++;
        sb_if.A_wb_valid_i = 1'b1; sb_if.A_wb_addr_i = 5'd7;
        sb_if.B_wb_valid_i = 1'b1; sb_if.B_wb_addr_i = 5'd7;
        tick();
        idle_inputs();
        #1;
        if (sb_if.busy_o !== '0) $display("[TB] FAIL dual_wb_clear: got %h want 0", sb_if.busy_o); else passCount++; checkCount++;
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd7; sb_if.A_rd_write_i = 1'b1;
        tick();
        idle_inputs();
        sb_if.flush_i = 1'b1;
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd8; sb_if.A_rd_write_i = 1'b1;
        sb_if.B_valid_i = 1'b1; sb_if.B_rd_addr_i = 5'd9; sb_if.B_rd_write_i = 1'b1;
        #1;
        if (sb_if.A_issue_o !== 1'b0 || sb_if.B_issue_o !== 1'b0)
            $display("[TB] FAIL flush_grants: got A=%b B=%b want A=0 B=0", sb_if.A_issue_o, sb_if.B_issue_o);
        else passCount++;
        checkCount++;
        tick();
        idle_inputs();
        #1;
        if (sb_if.busy_o !== '0) $display("[TB] FAIL flush_busy: got %h want 0", sb_if.busy_o); else passCount++; checkCount++;
        if (sb_if.stall_cnt_o !== 4'd6) $display("[TB] FAIL flush_cnt_kept: got %0d want 6", sb_if.stall_cnt_o); else passCount++; checkCount++;
    endtask

    task automatic test_saturation();
        int want;
        sb_if.A_valid_i = 1'b1; sb_if.A_rd_addr_i = 5'd4; sb_if.A_rd_write_i = 1'b1;
        tick();
        idle_inputs();
        sb_if.A_valid_i = 1'b1; sb_if.A_rs1_addr_i = 5'd4; sb_if.A_rs1_used_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1;
            want = (6 + i > 15) ? 15 : 6 + i;
            if (int'(sb_if.stall_cnt_o) !== want) $display("[TB] FAIL sat_cnt: got %0d want %0d", sb_if.stall_cnt_o, want); else passCount++; checkCount++;
        end
        reset_i = 1'b1;
        #1;
        if (sb_if.stall_o !== 1'b0) $display("[TB] FAIL sat_reset_stall: got %b want 0", sb_if.stall_o); else passCount++; checkCount++;
        tick();
        reset_i = 1'b0;
        idle_inputs();
        #1;
        if (sb_if.stall_cnt_o !== '0) $display("[TB] FAIL sat_reset_cnt: got %0d want 0", sb_if.stall_cnt_o); else passCount++; checkCount++;
        if (sb_if.busy_o !== '0) $display("[TB] FAIL sat_reset_busy: got %h want 0", sb_if.busy_o); else passCount++; checkCount++;
    endtask

    task automatic test_random();
        bit ea, eb, es;
        for (int n = 0; n < 400; n++) begin
            reset_i             = ($urandom_range(0, 99) == 0);
            sb_if.flush_i       = ($urandom_range(0, 29) == 0);
            sb_if.A_valid_i     = ($urandom_range(0, 3) != 0);
            sb_if.A_rs1_addr_i  = 5'($urandom_range(0, 7));
            sb_if.A_rs2_addr_i  = 5'($urandom_range(0, 7));
            sb_if.A_rs1_used_i  = 1'($urandom_range(0, 1));
            sb_if.A_rs2_used_i  = 1'($urandom_range(0, 1));
            sb_if.A_rd_addr_i   = 5'($urandom_range(0, 7));
            sb_if.A_rd_write_i  = 1'($urandom_range(0, 1));
            sb_if.B_valid_i     = ($urandom_range(0, 3) != 0);
            sb_if.B_rs1_addr_i  = 5'($urandom_range(0, 7));
            sb_if.B_rs2_addr_i  = 5'($urandom_range(0, 7));
            sb_if.B_rs1_used_i  = 1'($urandom_range(0, 1));
            sb_if.B_rs2_used_i  = 1'($urandom_range(0, 1));
            sb_if.B_rd_addr_i   = 5'($urandom_range(0, 7));
            sb_if.B_rd_write_i  = 1'($urandom_range(0, 1));
            sb_if.A_wb_valid_i  = 1'($urandom_range(0, 1));
            sb_if.B_wb_valid_i  = ($urandom_range(0, 3) == 0);
            sb_if.A_wb_addr_i   = (outstanding.size() > 0) ?
                                  5'(outstanding[$urandom_range(0, outstanding.size() - 1)]) : 5'($urandom_range(0, 7));
            sb_if.B_wb_addr_i   = (outstanding.size() > 0) ?
                                  5'(outstanding[$urandom_range(0, outstanding.size() - 1)]) : 5'($urandom_range(0, 7));
            #1;
            model_grants(ea, eb, es);
            if (sb_if.A_issue_o !== ea) $display("[TB] FAIL rnd_a_issue cyc%0d: got %b want %b", n, sb_if.A_issue_o, ea); else passCount++; checkCount++;
            if (sb_if.B_issue_o !== eb) $display("[TB] FAIL rnd_b_issue cyc%0d: got %b want %b", n, sb_if.B_issue_o, eb); else passCount++; checkCount++;
            if (sb_if.stall_o !== es) $display("[TB] FAIL rnd_stall cyc%0d: got %b want %b", n, sb_if.stall_o, es); else passCount++; checkCount++;
            if (sb_if.busy_o !== model_busy_vec()) $display("[TB] FAIL rnd_busy cyc%0d: got %h want %h", n, sb_if.busy_o, model_busy_vec()); else passCount++; checkCount++;
            if (sb_if.stall_cnt_o !== CNT_W'(model_cnt())) $display("[TB] FAIL rnd_cnt cyc%0d: got %0d want %0d", n, sb_if.stall_cnt_o, model_cnt()); else passCount++; checkCount++;
            tick();
        end
        reset_i = 1'b0;
        idle_inputs();
    endtask

    initial begin
        passCount   = 0;
        checkCount  = 0;
        stallCycles = 0;
        reset_i     = 1'b1;
        idle_inputs();
        @(posedge clock_i);
        @(negedge clock_i);
        test_reset();
        test_single_write();
        test_raw_stall();
        test_pair_hazard();
        test_x0();
        test_set_wins_flush();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
